// File: rtl/postfix_sched_if.sv
// Client/evaluator bundle for postfix_sched; slave is the scheduler side,
// master is the combined client + evaluator side.
interface postfix_sched_if;
  logic [1:0]  REQ;
  logic [1:0]  GNT;
  logic [1:0]  TOK_VALID;
  logic [1:0]  TOK_OP;
  logic [7:0]  TOK_VAL;
  logic [1:0]  TOK_LAST;
  logic [1:0]  TOK_READY;
  logic        EV_IN_VALID;
  logic        EV_OP_MODE;
  logic [3:0]  EV_IN;
  logic        EV_OUT_VALID;
  logic [15:0] EV_OUT;
  logic [1:0]  RES_VALID;
  logic [15:0] RES;
  logic [1:0]  RES_ERR;

  modport slave (
    input  REQ, TOK_VALID, TOK_OP, TOK_VAL, TOK_LAST, EV_OUT_VALID, EV_OUT,
    output GNT, TOK_READY, EV_IN_VALID, EV_OP_MODE, EV_IN, RES_VALID, RES, RES_ERR
  );

  modport master (
    output REQ, TOK_VALID, TOK_OP, TOK_VAL, TOK_LAST, EV_OUT_VALID, EV_OUT,
    input  GNT, TOK_READY, EV_IN_VALID, EV_OP_MODE, EV_IN, RES_VALID, RES, RES_ERR
  );
endinterface

// File: rtl/postfix_sched.sv
// Round-robin two-client scheduler: buffers one client's postfix tokens, checks them,
// replays them as a burst to the evaluator. Define PFX_TIMEOUT_EN for the WAIT watchdog.
module postfix_sched #(
  parameter int BUF_DEPTH = 32,
  parameter int TIMEOUT   = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  postfix_sched_if.slave bus
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_BURST  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] depth_q, depth_d;
  logic          mal_q, mal_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] rd_q, rd_d;
  logic [15:0]   res_q, res_d;
  logic [1:0]    err_q, err_d;
  logic [4:0]    buf_q [BUF_DEPTH];
  logic          wr_en;
`ifdef PFX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  logic       tok_v, tok_op, tok_last, op_legal;
  logic [3:0] tok_val;

  always_comb begin
    tok_v    = gnt_q[1] ? bus.TOK_VALID[1] : bus.TOK_VALID[0];
    tok_op   = gnt_q[1] ? bus.TOK_OP[1]    : bus.TOK_OP[0];
    tok_last = gnt_q[1] ? bus.TOK_LAST[1]  : bus.TOK_LAST[0];
    tok_val  = gnt_q[1] ? bus.TOK_VAL[7:4] : bus.TOK_VAL[3:0];
    op_legal = (tok_val == 4'd1) || (tok_val == 4'd2) || (tok_val == 4'd4);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    depth_d = depth_q;
    mal_d   = mal_q;
    ovf_d   = ovf_q;
    rd_d    = rd_q;
    res_d   = res_q;
    err_d   = err_q;
    wr_en   = 1'b0;
`ifdef PFX_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|bus.REQ) begin
          if (&bus.REQ) gnt_d = last_q ? 2'b01 : 2'b10;
          else          gnt_d = bus.REQ;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (tok_v) begin
          // A full buffer still drains the client; the token is dropped, not stalled.
          if (cnt_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
          if (!tok_op) begin
            depth_d = (depth_q == FULL) ? FULL : depth_q + CW'(1);
          end else begin
            if (depth_q < CW'(2) || !op_legal) mal_d = 1'b1;
            if (depth_q >= CW'(2)) depth_d = depth_q - CW'(1);
          end
          if (tok_last) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        rd_d  = '0;
        res_d = 16'd0;
        if (ovf_q) begin
          err_d   = 2'd2;
          state_d = S_RESULT;
        end else if (mal_q || depth_q != CW'(1)) begin
          err_d   = 2'd1;
          state_d = S_RESULT;
        end else begin
          err_d   = 2'd0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        rd_d = rd_q + CW'(1);
`ifdef PFX_TIMEOUT_EN
        tmo_d = '0;
`endif
        if (rd_q == cnt_q - CW'(1)) state_d = S_WAIT;
      end
      S_WAIT: begin
`ifdef PFX_TIMEOUT_EN
        tmo_d = tmo_q + TW'(1);
`endif
        if (bus.EV_OUT_VALID) begin
          res_d   = bus.EV_OUT;
          err_d   = 2'd0;
          state_d = S_RESULT;
        end
`ifdef PFX_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          res_d   = 16'd0;
          err_d   = 2'd3;
          state_d = S_RESULT;
        end
`endif
      end
      S_RESULT: begin
        last_d  = gnt_q[1];
        gnt_d   = 2'b00;
        cnt_d   = '0;
        depth_d = '0;
        mal_d   = 1'b0;
        ovf_d   = 1'b0;
        rd_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      depth_q <= '0;
      mal_q   <= 1'b0;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      depth_q <= depth_d;
      mal_q   <= mal_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
    end
  end

`ifdef PFX_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  always_ff @(posedge CLK) begin
    res_q <= res_d;
    err_q <= err_d;
    if (wr_en) buf_q[cnt_q[AW-1:0]] <= {tok_op, tok_val};
  end

  // Outputs are gated by state so an asynchronous reset silences them at once.
  assign bus.GNT         = gnt_q;
  assign bus.TOK_READY   = (state_q == S_LOAD) ? gnt_q : 2'b00;
  assign bus.EV_IN_VALID = (state_q == S_BURST);
  assign {bus.EV_OP_MODE, bus.EV_IN} = (state_q == S_BURST) ? buf_q[rd_q[AW-1:0]] : 5'd0;
  assign bus.RES_VALID   = (state_q == S_RESULT) ? gnt_q : 2'b00;
  assign bus.RES         = (state_q == S_RESULT) ? res_q : 16'd0;
  assign bus.RES_ERR     = (state_q == S_RESULT) ? err_q : 2'd0;
endmodule

// File: tb/tb_postfix_sched.sv
// Scoreboard bench for postfix_sched with a behavioural postfix evaluator (2-cycle latency).
module tb_postfix_sched;
  localparam int BUF_DEPTH = 32;
  localparam int TIMEOUT   = 8;
  localparam int BUDGET    = 300;

  typedef logic [4:0] tok_t;
  typedef struct {
    int          c;
    logic [15:0] res;
    logic [1:0]  err;
    int          blen;
    int          gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  postfix_sched_if bus();

  logic        req_c [2];
  logic        tv_c [2];
  logic        top_c [2];
  logic        tlast_c [2];
  logic [3:0]  tval_c [2];
  logic        ev_ov;
  logic [15:0] ev_out;
  bit          ev_silent;

  assign bus.REQ          = {req_c[1], req_c[0]};
  assign bus.TOK_VALID    = {tv_c[1], tv_c[0]};
  assign bus.TOK_OP       = {top_c[1], top_c[0]};
  assign bus.TOK_LAST     = {tlast_c[1], tlast_c[0]};
  assign bus.TOK_VAL      = {tval_c[1], tval_c[0]};
  assign bus.EV_OUT_VALID = ev_ov;
  assign bus.EV_OUT       = ev_out;

  postfix_sched #(.BUF_DEPTH(BUF_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [1:0] gnt_exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait budget expired", name);
  endtask

  function automatic tok_t opd(input int v);
    return {1'b0, 4'(v)};
  endfunction
  function automatic tok_t opr(input int v);
    return {1'b1, 4'(v)};
  endfunction

  task automatic push_exp(input int c, input int res, input int err, input int blen, input int gap);
    exp_t e;
    e.c = c; e.res = 16'(res); e.err = 2'(err); e.blen = blen; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Behavioural evaluator: consumes the burst, answers two cycles after it ends.
  initial begin
    logic [15:0] stk [64];
    int sp;
    bit in_b, pend;
    sp = 0; in_b = 0; pend = 0;
    ev_ov = 1'b0; ev_out = 16'd0;
    forever begin
      @(negedge clk);
      ev_ov = 1'b0;
      if (rst) begin
        sp = 0; in_b = 0; pend = 0;
      end else if (pend) begin
        pend = 0;
        if (!ev_silent) begin
          ev_ov  = 1'b1;
          ev_out = stk[0];
        end
        sp = 0;
      end else if (bus.EV_IN_VALID) begin
        in_b = 1;
        if (!bus.EV_OP_MODE) begin
          stk[sp] = 16'(bus.EV_IN);
          sp++;
        end else if (sp >= 2) begin
          case (bus.EV_IN)
            4'd1:    stk[sp-2] = stk[sp-2] + stk[sp-1];
            4'd2:    stk[sp-2] = stk[sp-2] - stk[sp-1];
            default: stk[sp-2] = stk[sp-2] * stk[sp-1];
          endcase
          sp--;
        end
      end else if (in_b) begin
        in_b = 0;
        pend = 1;
      end
    end
  end

  // Monitor: grant order, burst shape, wait gap and result scoreboard.
  initial begin
    int ev_cnt, ev_runs, gap;
    bit ev_prev;
    logic [1:0] gnt_prev;
    exp_t e;
    logic [1:0] ge;
    ev_cnt = 0; ev_runs = 0; gap = 0; ev_prev = 0; gnt_prev = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        ev_cnt = 0; ev_runs = 0; gap = 0; ev_prev = 0; gnt_prev = 2'b00;
      end else begin
        if (bus.EV_IN_VALID) begin
          if (!ev_prev) ev_runs++;
          ev_cnt++;
        end else if (ev_cnt > 0 && bus.RES_VALID == 2'b00) begin
          gap++;
        end
        ev_prev = bus.EV_IN_VALID;
        if (bus.GNT != 2'b00 && gnt_prev == 2'b00) begin
          if (gnt_exp_q.size() == 0) begin
            note_fail("unexpected_grant");
          end else begin
            ge = gnt_exp_q.pop_front();
            chk("gnt", 32'(bus.GNT), 32'(ge));
          end
        end
        gnt_prev = bus.GNT;
        if (bus.RES_VALID != 2'b00) begin
          if (exp_q.size() == 0) begin
            note_fail("unexpected_res_valid");
          end else begin
            e = exp_q.pop_front();
            chk("res_valid", 32'(bus.RES_VALID), 32'(2'b01 << e.c));
            chk("res", 32'(bus.RES), 32'(e.res));
            chk("res_err", 32'(bus.RES_ERR), 32'(e.err));
            chk("burst_len", 32'(ev_cnt), 32'(e.blen));
            chk("burst_runs", 32'(ev_runs), (e.blen > 0) ? 32'd1 : 32'd0);
            if (e.gap >= 0) chk("wait_gap", 32'(gap), 32'(e.gap));
          end
          ev_cnt = 0; ev_runs = 0; gap = 0;
        end
      end
    end
  end

  task automatic load_tokens(input int c, input tok_t toks[$], input int stall_at, output int waits);
    int n;
    waits = 0;
    req_c[c] = 1'b1;
    for (int i = 0; i < toks.size(); i++) begin
      if (i == stall_at) begin
        tv_c[c] = 1'b0;
        repeat (3) @(negedge clk);
      end
      tv_c[c]    = 1'b1;
      top_c[c]   = toks[i][4];
      tval_c[c]  = toks[i][3:0];
      tlast_c[c] = (i == toks.size() - 1);
      n = 0;
      while (!bus.TOK_READY[c] && n < BUDGET) begin
        @(negedge clk);
        n++;
      end
      if (n >= BUDGET) begin
        note_fail("tok_ready");
        break;
      end
      if (i > 0) waits += n;
      @(negedge clk);
    end
    tv_c[c]    = 1'b0;
    tlast_c[c] = 1'b0;
  endtask

  task automatic wait_result(input int c, input bit hold);
    int n;
    n = 0;
    while (!bus.RES_VALID[c] && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) note_fail("res_valid_wait");
    if (!hold) req_c[c] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    tok_t q0[$];
    tok_t q1[$];
    tok_t q2[$];
    int w, n;
    for (int i = 0; i < 2; i++) begin
      req_c[i] = 1'b0; tv_c[i] = 1'b0; top_c[i] = 1'b0; tlast_c[i] = 1'b0; tval_c[i] = 4'd0;
    end
    ev_silent = 0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.GNT), 32'd0);
    chk("rst_tok_ready", 32'(bus.TOK_READY), 32'd0);
    chk("rst_ev_in_valid", 32'(bus.EV_IN_VALID), 32'd0);
    chk("rst_res_valid", 32'(bus.RES_VALID), 32'd0);
    rst = 1'b0;

    // Tie from reset: client 0, client 1, then client 0 again.
    q0 = '{opd(3), opd(4), opr(1), opd(5), opr(4)};
    q1 = '{opd(7), opd(2), opr(2)};
    q2 = '{opd(6), opd(7), opr(4)};
    push_exp(0, 35, 0, 5, 2);
    push_exp(1, 5, 0, 3, 2);
    push_exp(0, 42, 0, 3, 2);
    gnt_exp_q.push_back(2'b01);
    gnt_exp_q.push_back(2'b10);
    gnt_exp_q.push_back(2'b01);
    fork
      begin
        int wa;
        load_tokens(0, q0, -1, wa);
        wait_result(0, 1'b1);
        load_tokens(0, q2, -1, wa);
        wait_result(0, 1'b0);
      end
      begin
        int wb, m;
        load_tokens(1, q1, -1, wb);
        wait_result(1, 1'b1);
        m = 0;
        while (!bus.GNT[0] && m < BUDGET) begin
          @(negedge clk);
          m++;
        end
        if (m >= BUDGET) note_fail("regrant_wait");
        req_c[1] = 1'b0;
      end
    join
    repeat (2) @(negedge clk);

    // Malformed: operator with depth 1.
    q0 = '{opd(3), opr(1)};
    gnt_exp_q.push_back(2'b10);
    push_exp(1, 0, 1, 0, -1);
    load_tokens(1, q0, -1, w);
    wait_result(1, 1'b0);

    // Malformed: illegal operator code 8.
    q0 = '{opd(1), opd(2), opr(8)};
    gnt_exp_q.push_back(2'b01);
    push_exp(0, 0, 1, 0, -1);
    load_tokens(0, q0, -1, w);
    wait_result(0, 1'b0);

    // Malformed: final depth 2.
    q0 = '{opd(1), opd(2)};
    gnt_exp_q.push_back(2'b10);
    push_exp(1, 0, 1, 0, -1);
    load_tokens(1, q0, -1, w);
    wait_result(1, 1'b0);

    // Overflow: 33 operands, all accepted back to back.
    q0.delete();
    for (int i = 0; i < BUF_DEPTH + 1; i++) q0.push_back(opd(1));
    gnt_exp_q.push_back(2'b01);
    push_exp(0, 0, 2, 0, -1);
    load_tokens(0, q0, -1, w);
    chk("ovf_ready_stalls", 32'(w), 32'd0);
    wait_result(0, 1'b0);

    // Client stall mid-expression: (9+1)*2 = 20.
    q0 = '{opd(9), opd(1), opr(1), opd(2), opr(4)};
    gnt_exp_q.push_back(2'b10);
    push_exp(1, 20, 0, 5, 2);
    load_tokens(1, q0, 3, w);
    wait_result(1, 1'b0);

`ifdef PFX_TIMEOUT_EN
    // Silent evaluator: watchdog fires after TIMEOUT wait cycles.
    ev_silent = 1;
    q0 = '{opd(5)};
    gnt_exp_q.push_back(2'b01);
    push_exp(0, 0, 3, 1, TIMEOUT);
    load_tokens(0, q0, -1, w);
    wait_result(0, 1'b0);
    ev_silent = 0;
    repeat (4) @(negedge clk);
`endif

    // Reset in the middle of a burst: no result may follow.
    q0 = '{opd(1), opd(2), opr(1), opd(3), opr(4)};
    gnt_exp_q.push_back(2'b01);
    load_tokens(0, q0, -1, w);
    n = 0;
    while (!bus.EV_IN_VALID && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) note_fail("burst_wait");
    @(negedge clk);
    chk("burst_mid", 32'(bus.EV_IN_VALID), 32'd1);
    rst = 1'b1;
    req_c[0] = 1'b0;
    #1;
    chk("rst_mid_gnt", 32'(bus.GNT), 32'd0);
    chk("rst_mid_ev_in_valid", 32'(bus.EV_IN_VALID), 32'd0);
    chk("rst_mid_res_valid", 32'(bus.RES_VALID), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("gnt_queue_empty", 32'(gnt_exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/postfix_sched.md
# postfix_sched

Two-client scheduler for the shared postfix evaluator. It grants the evaluator round-robin to one requester at a time and buffers that requester's token stream. It checks that the expression is well formed, replays it to the evaluator as one contiguous burst, and returns the 16-bit result or an error code to the granted client.

## Interface
- BUF_DEPTH, 32: token buffer entries; also the maximum expression length (evaluator stack limit).
- TIMEOUT, 8: cycles to wait for EV_OUT_VALID before aborting.
- CLK  in  1  single clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- REQ  in  2  per-client request, level.
- GNT  out  2  one-hot grant; held from grant until RES_VALID.
- TOK_VALID  in  2  per-client token valid.
- TOK_OP  in  2  per-client token kind: 0 = operand, 1 = operator.
- TOK_VAL  in  8  per-client 4-bit token value; client n uses [4n+3:4n].
- TOK_LAST  in  2  per-client marker for the final token of the expression.
- TOK_READY  out  2  token accept for the granted client.
- EV_IN_VALID  out  1  evaluator IN_VALID.
- EV_OP_MODE  out  1  evaluator OP_MODE.
- EV_IN  out  4  evaluator IN.
- EV_OUT_VALID  in  1  evaluator OUT_VALID.
- EV_OUT  in  16  evaluator OUT.
- RES_VALID  out  2  one-cycle result strobe to the granted client.
- RES  out  16  result value; valid while RES_VALID is high.
- RES_ERR  out  2  result status: 0 = ok, 1 = malformed, 2 = overflow, 3 = timeout.

## Operation
- The state machine has six states: IDLE, LOAD, CHECK, BURST, WAIT, RESULT.
- **IDLE:**
  - If any REQ bit is high, grant one client and go to LOAD.
  - If both request, grant the client that was not served last.
  - Reset sets "last served" to client 1, so client 0 wins the first tie.
- **LOAD:**
  - TOK_READY is high for the granted client only.
  - Each handshake (TOK_VALID & TOK_READY) writes {TOK_OP, TOK_VAL} into the buffer and increments count.
  - A depth tracker runs on every accepted token:
    - An operand adds 1 to depth.
    - An operator requires depth ≥ 2, then subtracts 1. Otherwise the malformed flag is set.
  - Legal operator codes are 1 (add), 2 (sub) and 4 (mul). Any other operator code sets the malformed flag.
  - If count == BUF_DEPTH when a token arrives, the overflow flag is set. The token is discarded and draining continues until TOK_LAST.
  - Accepting a token with TOK_LAST set goes to CHECK.
  - REQ changes after grant are ignored.
- **CHECK** (1 cycle):
  - A final depth other than 1 sets the malformed flag.
  - Overflow takes priority over malformed.
  - Any error: go to RESULT with that code, without touching the evaluator.
  - No error: go to BURST.
- **BURST:**
  - Replays buffer entries 0..count-1, one per cycle.
  - EV_IN_VALID stays high for exactly count consecutive cycles.
  - EV_OP_MODE and EV_IN come from each entry.
  - After the last entry, go to WAIT.
- **WAIT:**
  - On the first cycle with EV_OUT_VALID high, capture EV_OUT into RES and go to RESULT with error 0.
  - The watchdog is described under Configuration.
- **RESULT** (1 cycle):
  - The granted bit of RES_VALID is high, with RES and RES_ERR valid.
  - Update "last served", clear count, depth and flags, and go to IDLE.
- Arithmetic:
  - The depth counter is 6 bits and saturates at BUF_DEPTH.
  - RES is EV_OUT unmodified.
  - On error, RES = 0.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE, count and depth are 0, and "last served" is client 1.
- Reset asserted mid-operation aborts the operation immediately. No RES_VALID is produced.
- GNT rises one cycle after REQ is sampled in IDLE. TOK_READY rises in that same cycle.
- The CHECK cycle follows the cycle that accepted TOK_LAST.
- EV_IN_VALID first goes high in the cycle after CHECK.
- RES_VALID is asserted the cycle after EV_OUT_VALID is first seen.
- GNT falls the cycle after RES_VALID.
- The earliest next grant comes one cycle after that, since IDLE lasts at least 1 cycle.
- Ok-path latency from TOK_LAST accept to RES_VALID is 1 + count + evaluator latency + 1 cycles.

## Configuration
- **PFX_TIMEOUT_EN defined:**
  - The WAIT state counts cycles.
  - If EV_OUT_VALID has not appeared after TIMEOUT cycles, go to RESULT with RES_ERR = 3 and RES = 0.
  - A late EV_OUT_VALID that arrives in IDLE is ignored.
- **PFX_TIMEOUT_EN undefined:** WAIT waits indefinitely, and RES_ERR never takes the value 3.

## Test plan
- **Valid expression:** client 0 sends 3, 4, add(1), 5, mul(4), with LAST on the final token; the evaluator model returns 35.
  - Required: EV_IN_VALID high for 5 consecutive cycles.
  - Required: RES_VALID[0] pulse with RES = 35, RES_ERR = 0.
- **Round-robin tie:** REQ = 2'b11 from reset.
  - Required: GNT = 01 first, then GNT = 10 after client 0's RES_VALID, then 01 again if both still request.
- **Malformed expression:** tokens 3, add(1), LAST.
  - Required: RES_ERR = 1 and RES = 0.
  - Required: EV_IN_VALID never asserted.
  - Repeat with illegal operator code 8, and with operands 1, 2 only (final depth 2): both give RES_ERR = 1.
- **Buffer overflow:** with BUF_DEPTH = 32, send 33 operands, LAST on the 33rd.
  - Required: all 33 tokens are accepted (TOK_READY stays high) and RES_ERR = 2.
- **Client stall:** TOK_VALID is low for 3 cycles in the middle of the expression.
  - Required: the evaluator burst is still contiguous and the result is correct.
- **Timeout and reset:** with PFX_TIMEOUT_EN defined and the evaluator model silent, RES_ERR = 3 exactly TIMEOUT cycles after the burst ends.
  - Required: RESET asserted mid-BURST zeroes GNT and EV_IN_VALID immediately, and no RES_VALID follows.
